register_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage register stall table.
- Tracks outstanding writes per architectural register with a saturating in-flight counter, so several writes to one register can be pending at once.
- Checks NUM_RD source operands in parallel and asserts a combinational stall to the decode/register-access stage.
- Supports a pipeline flush and an optional writeback bypass.

---
 rtl/register_scoreboard.sv | 133 +++++++++++++
 tb/tb_register_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// register_scoreboard
//   Decode-stage register scoreboard. Every architectural register has a
//   saturating in-flight write counter, so several writes to one register
//   can be outstanding at once. NUM_RD source operands are checked in
//   parallel and a combinational stall is raised towards decode.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   reset            asynchronous active-low reset, clears all state
//   flush            synchronous clear of every counter (wins over alloc/retire)
//   wb_reg/_is_valid register retiring a write this cycle
//   dst_reg/_is_valid destination of the instruction sitting in decode
//   src_regs         packed source indices, port i at [i*REG_W +: REG_W]
//   src_is_valid     per-port source valid
//   next_stage_ready downstream accepts the decode instruction
//   is_stall         combinational stall to decode
//   pending_mask     bit r set while register r has writes in flight
//   underflow_err    sticky: a writeback arrived for a register with count 0
//
// Optional build macro
//   REGISTER_SCOREBOARD_WB_BYPASS_EN : a source whose only outstanding write
//   is retiring this cycle is forwarded and does not stall.

module register_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int REG_W    = 3,
    parameter int NUM_RD   = 4,
    parameter int CNT_W    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [REG_W-1:0]        wb_reg,
    input  logic                    wb_is_valid,
    input  logic [REG_W-1:0]        dst_reg,
    input  logic                    dst_reg_is_valid,
    input  logic [NUM_RD*REG_W-1:0] src_regs,
    input  logic [NUM_RD-1:0]       src_is_valid,
    input  logic                    next_stage_ready,
    output logic                    is_stall,
    output logic [NUM_REGS-1:0]     pending_mask,
    output logic                    underflow_err
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    logic [CNT_W-1:0] count_q [NUM_REGS];
    logic [CNT_W-1:0] count_d [NUM_REGS];
    logic             underflow_q;
    logic             underflow_d;

    logic             src_hazard;
    logic             dst_sat;
    logic             alloc;
    logic             retire;

    // Indices beyond NUM_REGS read as an idle register.
    function automatic logic in_range(input logic [REG_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input logic [REG_W-1:0] idx);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (in_range(idx) && (idx == REG_W'(r))) begin
                c = count_q[r];
            end
        end
        return c;
    endfunction

    always_comb begin
        src_hazard = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (src_is_valid[i] && (cnt_of(src_regs[i*REG_W +: REG_W]) != '0)) begin
`ifdef REGISTER_SCOREBOARD_WB_BYPASS_EN
                // Last outstanding write retires now: value is forwarded.
                if (!(wb_is_valid && (wb_reg == src_regs[i*REG_W +: REG_W]) &&
                      (cnt_of(src_regs[i*REG_W +: REG_W]) == CNT_W'(1)))) begin
                    src_hazard = 1'b1;
                end
`else
                src_hazard = 1'b1;
`endif
            end
        end

        dst_sat  = dst_reg_is_valid && (cnt_of(dst_reg) == MAX_CNT);
        is_stall = src_hazard || dst_sat;

        // Stall is decided on the pre-allocation counts, so src == dst in the
        // same instruction never stalls on itself.
        alloc  = dst_reg_is_valid && next_stage_ready && !is_stall && in_range(dst_reg);
        retire = wb_is_valid && in_range(wb_reg) && (cnt_of(wb_reg) != '0);

        underflow_d = underflow_q || (wb_is_valid && (cnt_of(wb_reg) == '0));

        for (int r = 0; r < NUM_REGS; r++) begin
            count_d[r] = count_q[r];
            if (flush) begin
                count_d[r] = '0;
            end else if (alloc && (dst_reg == REG_W'(r)) &&
                         !(retire && (wb_reg == REG_W'(r)))) begin
                count_d[r] = count_q[r] + CNT_W'(1);
            end else if (retire && (wb_reg == REG_W'(r)) &&
                         !(alloc && (dst_reg == REG_W'(r)))) begin
                count_d[r] = count_q[r] - CNT_W'(1);
            end
        end

        for (int r = 0; r < NUM_REGS; r++) begin
            pending_mask[r] = (count_q[r] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= '0;
            end
            underflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= count_d[r];
            end
            underflow_q <= underflow_d;
        end
    end

    assign underflow_err = underflow_q;

endmodule

// File: tb/tb_register_scoreboard.sv
module tb_register_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [2:0]  wb_reg;
    logic        wb_is_valid;
    logic [2:0]  dst_reg;
    logic        dst_reg_is_valid;
    logic [11:0] src_regs;
    logic [3:0]  src_is_valid;
    logic        next_stage_ready;
    logic        is_stall;
    logic [7:0]  pending_mask;
    logic        underflow_err;

    int n_vec = 0;
    int n_err = 0;

    register_scoreboard dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .wb_reg           (wb_reg),
        .wb_is_valid      (wb_is_valid),
        .dst_reg          (dst_reg),
        .dst_reg_is_valid (dst_reg_is_valid),
        .src_regs         (src_regs),
        .src_is_valid     (src_is_valid),
        .next_stage_ready (next_stage_ready),
        .is_stall         (is_stall),
        .pending_mask     (pending_mask),
        .underflow_err    (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush            = 1'b0;
        wb_reg           = 3'd0;
        wb_is_valid      = 1'b0;
        dst_reg          = 3'd0;
        dst_reg_is_valid = 1'b0;
        src_regs         = 12'h000;
        src_is_valid     = 4'b0000;
        next_stage_ready = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; combinational checks
    // follow 1 unit later, registered checks 1 unit after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic [2:0] r);
        idle();
        dst_reg          = r;
        dst_reg_is_valid = 1'b1;
        next_stage_ready = 1'b1;
    endtask

    task automatic wb(input logic [2:0] r);
        idle();
        wb_reg      = r;
        wb_is_valid = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #1;
        chk("rst_mask",  32'(pending_mask),  32'h00);
        chk("rst_uf",    32'(underflow_err), 32'h0);
        chk("rst_stall", 32'(is_stall),      32'h0);
        #12 reset = 1'b1;
        tick();

        // Allocate reg 3, then read it on source port 2.
        alloc(3'd3);
        #1 chk("a_alloc_stall", 32'(is_stall), 32'h0);
        tick();
        chk("a_mask", 32'(pending_mask), 32'h08);
        idle();
        src_regs = 12'h0C0; src_is_valid = 4'b0000;
        #1 chk("a_src_invalid", 32'(is_stall), 32'h0);
        src_is_valid = 4'b0100;
        #1 chk("a_src_hazard", 32'(is_stall), 32'h1);
        wb_reg = 3'd3; wb_is_valid = 1'b1;
`ifdef REGISTER_SCOREBOARD_WB_BYPASS_EN
        #1 chk("a_wb_cycle", 32'(is_stall), 32'h0);
`else
        #1 chk("a_wb_cycle", 32'(is_stall), 32'h1);
`endif
        tick();
        wb_is_valid = 1'b0;
        #1 chk("a_after_wb", 32'(is_stall), 32'h0);
        chk("a_mask_clr", 32'(pending_mask), 32'h00);
        chk("a_uf", 32'(underflow_err), 32'h0);

        // Saturate reg 5 (three allocs), fourth stalls.
        for (int k = 0; k < 3; k++) begin
            alloc(3'd5);
            #1 chk("b_alloc_ok", 32'(is_stall), 32'h0);
            tick();
        end
        chk("b_mask", 32'(pending_mask), 32'h20);
        alloc(3'd5);
        #1 chk("b_sat_stall", 32'(is_stall), 32'h1);
        wb_reg = 3'd5; wb_is_valid = 1'b1;
        #1 chk("b_sat_stall_wb", 32'(is_stall), 32'h1);
        tick();
        // count[5] should now be 2: one more alloc fits, then saturates again.
        alloc(3'd5);
        #1 chk("b_cnt2_nostall", 32'(is_stall), 32'h0);
        tick();
        alloc(3'd5);
        #1 chk("b_cnt3_stall", 32'(is_stall), 32'h1);
        for (int k = 0; k < 3; k++) begin
            wb(3'd5);
            tick();
            if (k == 1) chk("b_mask_two_wb", 32'(pending_mask), 32'h20);
        end
        chk("b_mask_drained", 32'(pending_mask), 32'h00);

        // Same-register alloc+retire keeps count 1.
        alloc(3'd1);
        tick();
        alloc(3'd1);
        wb_reg = 3'd1; wb_is_valid = 1'b1;
        #1 chk("c_same_stall", 32'(is_stall), 32'h0);
        tick();
        chk("c_same_mask", 32'(pending_mask), 32'h02);
        wb(3'd1);
        tick();
        chk("c_same_cnt1", 32'(pending_mask), 32'h00);
        // Different-register alloc+retire both apply.
        alloc(3'd4);
        tick();
        alloc(3'd2);
        wb_reg = 3'd4; wb_is_valid = 1'b1;
        tick();
        chk("c_diff_mask", 32'(pending_mask), 32'h04);
        wb(3'd2);
        tick();
        chk("c_diff_clr", 32'(pending_mask), 32'h00);
        chk("c_no_uf", 32'(underflow_err), 32'h0);

        // Underflow is sticky through flush.
        wb(3'd6);
        tick();
        chk("d_uf_set", 32'(underflow_err), 32'h1);
        chk("d_uf_mask", 32'(pending_mask), 32'h00);
        idle();
        flush = 1'b1;
        tick();
        chk("d_uf_flush", 32'(underflow_err), 32'h1);

        // Flush overrides a concurrent alloc.
        alloc(3'd0); tick();
        alloc(3'd1); tick();
        alloc(3'd7); tick();
        chk("e_mask_pre", 32'(pending_mask), 32'h83);
        alloc(3'd2);
        flush = 1'b1;
        #1 chk("e_flush_stall", 32'(is_stall), 32'h0);
        tick();
        chk("e_flush_mask", 32'(pending_mask), 32'h00);
        alloc(3'd3);
        next_stage_ready = 1'b0;
        #1 chk("e_notready_stall", 32'(is_stall), 32'h0);
        tick();
        chk("e_notready_mask", 32'(pending_mask), 32'h00);

        // Asynchronous reset mid-run with count[3]=2.
        alloc(3'd3); tick();
        alloc(3'd3); tick();
        idle();
        chk("f_mask_pre", 32'(pending_mask), 32'h08);
        src_regs = 12'h0C0; src_is_valid = 4'b0100;
        #1 chk("f_stall_pre", 32'(is_stall), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("f_rst_mask",  32'(pending_mask),  32'h00);
        chk("f_rst_uf",    32'(underflow_err), 32'h0);
        chk("f_rst_stall", 32'(is_stall),      32'h0);
        idle();
        #1 chk("f_rst_idle_stall", 32'(is_stall), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        chk("f_post_mask", 32'(pending_mask), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
